// File: rtl/alu_exec_stage.sv
// Registered ALU stage: computes one of nine ops on WIDTH-bit operands, adds flags and an accumulator.
// Latency: result visible the cycle after accept when the output buffer was empty; 1 op/cycle sustained.
// Backpressure: 2-entry buffer; in_ready depends only on buffer occupancy, never combinationally on out_ready.

// Small generic FIFO: first-word-fall-through, registered occupancy.
module alu_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  output logic          push_rdy,
  input  logic [DW-1:0] push_dat,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [DW-1:0] pop_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign push_rdy = (r_count < CW'(DEPTH));
  assign pop_vld  = (r_count != '0);
  assign pop_dat  = r_mem[r_rd_ptr];
  assign w_push   = push_vld && push_rdy;
  assign w_pop    = pop_vld && pop_rdy;

  // Storage write and write-pointer advance on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
      r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    end
  end

  // Read-pointer advance and occupancy tracking; push+pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module alu_exec_stage #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opS,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             clear_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  output logic [WIDTH-1:0] acc
);
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR  = 4'd4, OP_XOR = 4'd5, OP_INV = 4'd6, OP_SHL = 4'd7,
                         OP_SHR = 4'd8;
  localparam int PW = WIDTH + 5;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_opa;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_err;
  logic             w_wr_acc;
  logic [3:0]       w_flags;
  logic             w_accept;
  logic [PW-1:0]    w_push_dat;
  logic [PW-1:0]    w_head;

  assign w_opa = use_acc ? r_acc : a;
  assign w_sh  = b[SHW-1:0];

  // Operation datapath: result, carry/borrow, overflow, and whether the accumulator follows.
  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    w_wr_acc = 1'b0;
    case (opS)
      OP_NOP: w_res = w_opa;
      OP_ADD: begin
        {w_c, w_res} = {1'b0, w_opa} + {1'b0, b};
        w_v      = (w_opa[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != w_opa[WIDTH-1]);
        w_wr_acc = 1'b1;
      end
      OP_SUB: begin
        // The extra top bit of the difference is the unsigned borrow.
        {w_c, w_res} = {1'b0, w_opa} - {1'b0, b};
        w_v      = (w_opa[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != w_opa[WIDTH-1]);
        w_wr_acc = 1'b1;
      end
      OP_AND: begin w_res = w_opa & b; w_wr_acc = 1'b1; end
      OP_OR:  begin w_res = w_opa | b; w_wr_acc = 1'b1; end
      OP_XOR: begin w_res = w_opa ^ b; w_wr_acc = 1'b1; end
      OP_INV: begin w_res = ~w_opa;    w_wr_acc = 1'b1; end
      OP_SHL: begin
        // A guard bit above the operand catches the last bit shifted out (0 for shift 0).
        {w_c, w_res} = {1'b0, w_opa} << w_sh;
        w_wr_acc = 1'b1;
      end
      OP_SHR: begin
        {w_res, w_c} = {w_opa, 1'b0} >> w_sh;
        w_wr_acc = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
    w_flags = w_err ? 4'b0000 : {(w_res == '0), w_res[WIDTH-1], w_c, w_v};
  end

  assign w_accept   = in_valid && in_ready;
  assign w_push_dat = {w_err, w_flags, w_res};

  // Accumulator: clear wins over the update from an op accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_acc <= '0;
    else if (clear_acc)            r_acc <= '0;
    else if (w_accept && w_wr_acc) r_acc <= w_res;
  end

  alu_fifo #(.DW(PW), .DEPTH(2)) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (w_push_dat),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (w_head)
  );

  // Outputs read zero while the buffer is empty so nothing stale is presented.
  assign result = out_valid ? w_head[WIDTH-1:0]       : '0;
  assign flags  = out_valid ? w_head[WIDTH+3:WIDTH]   : 4'b0000;
  assign err    = out_valid ? w_head[WIDTH+4]         : 1'b0;
  assign acc    = r_acc;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed scenarios plus randomized traffic against an arithmetic reference model.
// Latency: checks every cycle at the falling edge against a queue of expected entries.
// Backpressure: randomizes out_ready and holds requests stable until accepted.
module tb_alu_exec_stage;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  typedef struct {
    int res;
    int flg;
    int er;
  } ent_t;

  logic         clk, rst_n;
  logic         in_valid, in_ready, use_acc, clear_acc, out_valid, out_ready, err;
  logic [3:0]   opS, flags;
  logic [W-1:0] a, b, result, acc;

  ent_t q[$];
  int   m_acc;
  int   n_chk, n_err;
  bit   last_fire;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opS(opS),
    .a(a), .b(b), .use_acc(use_acc), .clear_acc(clear_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .err(err), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= HALF) ? v - (1 << W) : v;
  endfunction

  // Reference behaviour written from the arithmetic definition of each operation.
  function automatic ent_t model_op(input int op, input int av, input int bv);
    ent_t e;
    int   c, v, sr, sh;
    c  = 0;
    v  = 0;
    sh = bv % W;
    e.er = 0;
    e.res = 0;
    case (op)
      0: e.res = av;
      1: begin
        e.res = (av + bv) & MASK;
        c = (av + bv > MASK) ? 1 : 0;
        sr = sgn(av) + sgn(bv);
        v = (sr >= HALF || sr < -HALF) ? 1 : 0;
      end
      2: begin
        e.res = (av - bv) & MASK;
        c = (av < bv) ? 1 : 0;
        sr = sgn(av) - sgn(bv);
        v = (sr >= HALF || sr < -HALF) ? 1 : 0;
      end
      3: e.res = av & bv;
      4: e.res = av | bv;
      5: e.res = av ^ bv;
      6: e.res = MASK - av;
      7: begin
        e.res = (av * (1 << sh)) & MASK;
        c = (sh > 0) ? (av >> (W - sh)) & 1 : 0;
      end
      8: begin
        e.res = av / (1 << sh);
        c = (sh > 0) ? (av >> (sh - 1)) & 1 : 0;
      end
      default: e.er = 1;
    endcase
    if (e.er == 1) e.flg = 0;
    else e.flg = ((e.res == 0) ? 8 : 0) + ((e.res >= HALF) ? 4 : 0) + c * 2 + v;
    return e;
  endfunction

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic cycle();
    ent_t e;
    bit   fire_in, fire_out;
    @(negedge clk);
    chk("out_valid", out_valid, (q.size() > 0));
    chk("in_ready", in_ready, (q.size() < 2));
    chk("acc", acc, m_acc);
    if (q.size() > 0) begin
      chk("result", result, q[0].res);
      chk("flags", flags, q[0].flg);
      chk("err", err, q[0].er);
    end
    fire_in  = in_valid && (q.size() < 2);
    fire_out = (q.size() > 0) && out_ready;
    e = model_op(int'(opS), use_acc ? m_acc : int'(a), int'(b));
    if (fire_out) void'(q.pop_front());
    if (fire_in) q.push_back(e);
    if (clear_acc) m_acc = 0;
    else if (fire_in && opS >= 4'd1 && opS <= 4'd8) m_acc = e.res;
    last_fire = fire_in;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int av, input int bv, input bit ua);
    in_valid = 1'b1;
    opS = 4'(op);
    a = W'(av);
    b = W'(bv);
    use_acc = ua;
    cycle();
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_acc = 0; last_fire = 0;
    rst_n = 1'b0; in_valid = 1'b0; opS = '0; a = '0; b = '0;
    use_acc = 1'b0; clear_acc = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst result", result, 0);
    chk("rst flags", flags, 0);
    chk("rst err", err, 0);
    chk("rst acc", acc, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic examples with explicit expected values.
    issue(1, 200, 100, 0);
    chk("add1 result", result, 8'h2C); chk("add1 flags", flags, 4'b0010); chk("add1 acc", acc, 8'h2C);
    issue(1, 8'h7F, 8'h01, 0);
    chk("add2 result", result, 8'h80); chk("add2 flags", flags, 4'b0101);
    issue(2, 5, 6, 0);
    chk("sub result", result, 8'hFF); chk("sub flags", flags, 4'b0110);
    issue(7, 8'h81, 1, 0);
    chk("shl result", result, 8'h02); chk("shl flags", flags, 4'b0010);
    issue(8, 8'h81, 0, 0);
    chk("shr0 result", result, 8'h81); chk("shr0 flags", flags, 4'b0100);
    issue(8, 8'h10, 4, 0);
    chk("shr4 result", result, 8'h01); chk("shr4 flags", flags, 4'b0000);

    // Accumulator chaining with no bubbles, then an illegal opcode.
    in_valid = 1'b0; clear_acc = 1'b1;
    cycle();
    clear_acc = 1'b0;
    chk("clear acc", acc, 0);
    issue(1, 0, 5, 1); chk("chain1", result, 5);
    issue(1, 0, 5, 1); chk("chain2", result, 10);
    issue(1, 0, 5, 1); chk("chain3", result, 15); chk("chain acc", acc, 15);
    issue(12, 8'h33, 8'h44, 0);
    chk("illegal result", result, 0); chk("illegal err", err, 1);
    chk("illegal flags", flags, 0); chk("illegal acc", acc, 15);
    in_valid = 1'b0;
    cycle();

    // Backpressure: third request held until space frees, order preserved.
    out_ready = 1'b0;
    issue(3, 8'h0F, 8'hF0, 0);
    issue(4, 8'h0F, 8'hF0, 0);
    issue(5, 8'hFF, 8'h55, 0);
    chk("bp in_ready", in_ready, 0);
    cycle();
    chk("bp head", result, 8'h00); chk("bp head flags", flags, 4'b1000);
    out_ready = 1'b1;
    cycle();
    chk("bp second", result, 8'hFF);
    cycle();
    chk("bp third", result, 8'hAA); chk("bp third flags", flags, 4'b0100);
    in_valid = 1'b0;
    repeat (2) cycle();

    // Reset while the buffer holds two entries.
    out_ready = 1'b0;
    issue(1, 1, 2, 0);
    issue(1, 3, 4, 0);
    in_valid = 1'b0;
    chk("pre-rst count", in_ready, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst acc", acc, 0);
    q.delete();
    m_acc = 0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();

    // Randomized traffic; a pending request stays unchanged until accepted.
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        opS      = 4'($urandom_range(0, 11));
        a        = W'($urandom);
        b        = W'($urandom);
        use_acc  = $urandom_range(0, 1) == 1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clear_acc = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid = 1'b0; clear_acc = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Parametrised, registered successor to the combinational ALU result selector.
- Computes all nine ALU operations on WIDTH-bit operands and selects one by opcode.
- Adds status flags, an accumulator operand mode, and a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between the instruction/operand source and the register write-back path.

Parameters:
- WIDTH, 8, operand/result width; power of two, at least 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  stage can accept a request.
- opS  in  4  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 INVERT, 7 SHL, 8 SHR, 9-15 illegal.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b[SHW-1:0].
- use_acc  in  1  replace operand A with the accumulator.
- clear_acc  in  1  synchronous accumulator clear (independent of in_valid).
- out_valid  out  1  result entry valid.
- out_ready  in  1  consumer accepts the entry.
- result  out  WIDTH  head-entry result.
- flags  out  4  head-entry {Z, N, C, V}.
- err  out  1  head entry came from an illegal opcode.
- acc  out  WIDTH  current accumulator value.

Behaviour:
- Reset (async assert, sync-safe deassert): buffer empty, out_valid=0, result=0, flags=0, err=0, acc=0, in_ready=1.
- Accept when in_valid && in_ready. Compute from the inputs and the current acc; write into the 2-entry FIFO.
- Latency: out_valid rises the cycle after accept if the buffer was empty.
- in_ready = (count < 2). It is a registered function of state only, with no combinational path from out_ready.
- Pop when out_valid && out_ready.
- Simultaneous push and pop: count unchanged, order preserved. Sustained throughput is 1 op/cycle.
- result, flags and err are stable while out_valid && !out_ready.
- Operand A is acc when use_acc=1, otherwise a.
- NOP: result = A; no flags beyond Z/N.
- ADD: result = A+B mod 2^WIDTH. C = carry out. V = signed overflow.
- SUB: result = A-B mod 2^WIDTH. C = borrow (A<B unsigned). V = signed overflow.
- AND/OR/XOR: bitwise. INVERT: ~A. For these, C=0 and V=0.
- SHL/SHR: logical shift of A by b[SHW-1:0], zero fill. C = last bit shifted out; C=0 for a shift of 0. V=0.
- Z = (result==0). N = result[WIDTH-1].
- Illegal opcode: result=0, flags=0, err=1, acc unchanged.
- Accumulator update: on accept of ADD..SHR, acc <= result. NOP and illegal opcodes leave acc unchanged.
- clear_acc=1: acc <= 0. It takes priority over a same-cycle update, but the op accepted that cycle still computes with the old acc.
- Back-to-back use_acc ops see each predecessor's result, with no bubble.
- Reset asserted mid-operation: the buffer is flushed immediately (out_valid drops asynchronously), acc=0, in-flight entries are lost.

Test Plan:
- Reset, then ADD a=200 b=100 (WIDTH=8), out_ready=1 -> next cycle result=0x2C, flags Z0 N0 C1 V0, acc=0x2C.
- ADD a=0x7F b=0x01 -> result=0x80, N1 C0 V1. Then SUB a=5 b=6 -> result=0xFF, N1 C1 V0.
- SHL a=0x81 b=1 -> 0x02, C1. SHR a=0x81 b=0 -> 0x81, C0, N1. SHR a=0x10 b=4 -> 0x01, C0.
- clear_acc, then three ADDs use_acc=1 b=5 on consecutive cycles -> results 5, 10, 15 and acc=15. Then opS=12 -> result 0, err=1, acc stays 15.
- Backpressure: out_ready=0, issue ops AND(0x0F,0xF0), OR(0x0F,0xF0), XOR(0xFF,0x55). First two accepted; in_ready=0 with the third held stable. Raise out_ready -> outputs 0x00 (Z1), 0xFF, 0xAA in order, no loss or duplication.
- Fill the buffer with 2 entries, pulse rst_n low mid-cycle -> out_valid=0 and acc=0 immediately, in_ready=1 after release, no stale entry emitted.
